// File: rtl/rst_seq.sv
// Reset sequencer: synchronises and filters the pin reset, merges it with the software request,
// stretches the combined request, then releases N_OUT domain resets in order, one every STAGE_DLY cycles.
module rst_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 3,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned STAGE_DLY   = 8,
    parameter int unsigned N_OUT       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_rst_n,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_out_n,
    output logic             all_released,
    output logic [1:0]       last_cause,
    output logic [7:0]       rst_count
);

    localparam int unsigned FLT_W = (FILTER    > 1) ? $clog2(FILTER)    : 1;
    localparam int unsigned STR_W = (STRETCH   > 1) ? $clog2(STRETCH)   : 1;
    localparam int unsigned DLY_W = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
    localparam int unsigned STG_W = (N_OUT     > 1) ? $clog2(N_OUT)     : 1;

    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(N_OUT - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FLT_W-1:0]       filt_cnt_q, filt_cnt_d;
    logic                   ext_active_q, ext_active_d;
    logic [1:0]             state_q, state_d;
    logic [STR_W-1:0]       str_cnt_q, str_cnt_d;
    logic [DLY_W-1:0]       dly_cnt_q, dly_cnt_d;
    logic [STG_W-1:0]       stage_q, stage_d;
    logic [N_OUT-1:0]       rst_out_n_q, rst_out_n_d;
    logic                   all_released_q, all_released_d;
    logic [1:0]             last_cause_q, last_cause_d;
    logic [7:0]             rst_count_q, rst_count_d;

    logic ext_sync;
    logic rst_req;

    assign ext_sync = sync_q[SYNC_STAGES-1];
    assign rst_req  = ext_active_q | sw_rst_req;

    // Pin synchroniser and low-pulse filter; deassertion is not filtered.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], ext_rst_n};
        filt_cnt_d   = filt_cnt_q;
        ext_active_d = ext_active_q;
        if (ext_sync) begin
            filt_cnt_d   = '0;
            ext_active_d = 1'b0;
        end else if (filt_cnt_q == FLT_LAST) begin
            ext_active_d = 1'b1;
        end else begin
            filt_cnt_d = filt_cnt_q + FLT_W'(1);
        end
    end

    // Sequencer next state and registered outputs.
    always_comb begin
        state_d        = state_q;
        str_cnt_d      = str_cnt_q;
        dly_cnt_d      = dly_cnt_q;
        stage_d        = stage_q;
        rst_out_n_d    = rst_out_n_q;
        all_released_d = all_released_q;
        last_cause_d   = last_cause_q;
        rst_count_d    = rst_count_q;

        case (state_q)
            ST_ASSERT: begin
                rst_out_n_d    = '0;
                all_released_d = 1'b0;
                if (rst_req) begin
                    str_cnt_d = '0;
                end else if (str_cnt_q == STR_LAST) begin
                    state_d   = ST_RELEASE;
                    str_cnt_d = '0;
                    dly_cnt_d = '0;
                    stage_d   = '0;
                end else begin
                    str_cnt_d = str_cnt_q + STR_W'(1);
                end
            end
            ST_RELEASE: begin
                if (dly_cnt_q == DLY_LAST) begin
                    rst_out_n_d[stage_q] = 1'b1;
                    dly_cnt_d            = '0;
                    if (stage_q == STG_LAST) begin
                        state_d        = ST_RUN;
                        stage_d        = '0;
                        all_released_d = 1'b1;
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            ST_RUN: begin
                rst_out_n_d    = '1;
                all_released_d = 1'b1;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // A new request outside ASSERT aborts the sequence and is logged.
        if (rst_req && (state_q != ST_ASSERT)) begin
            state_d        = ST_ASSERT;
            str_cnt_d      = '0;
            dly_cnt_d      = '0;
            stage_d        = '0;
            rst_out_n_d    = '0;
            all_released_d = 1'b0;
            last_cause_d   = {sw_rst_req, ext_active_q};
            if (rst_count_q != 8'hFF) begin
                rst_count_d = rst_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q         <= '0;
            filt_cnt_q     <= '0;
            ext_active_q   <= 1'b1;
            state_q        <= ST_ASSERT;
            str_cnt_q      <= '0;
            dly_cnt_q      <= '0;
            stage_q        <= '0;
            rst_out_n_q    <= '0;
            all_released_q <= 1'b0;
            last_cause_q   <= 2'b00;
            rst_count_q    <= 8'd0;
        end else begin
            sync_q         <= sync_d;
            filt_cnt_q     <= filt_cnt_d;
            ext_active_q   <= ext_active_d;
            state_q        <= state_d;
            str_cnt_q      <= str_cnt_d;
            dly_cnt_q      <= dly_cnt_d;
            stage_q        <= stage_d;
            rst_out_n_q    <= rst_out_n_d;
            all_released_q <= all_released_d;
            last_cause_q   <= last_cause_d;
            rst_count_q    <= rst_count_d;
        end
    end

    assign rst_out_n    = rst_out_n_q;
    assign all_released = all_released_q;
    assign last_cause   = last_cause_q;
    assign rst_count    = rst_count_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters; inputs change 1 ns after each rising edge,
// outputs are observed at the same point.
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_rst_n;
    logic       sw_rst_req;
    logic [3:0] rst_out_n;
    logic       all_released;
    logic [1:0] last_cause;
    logic [7:0] rst_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    rst_seq dut (
        .clk          (clk),
        .reset        (reset),
        .ext_rst_n    (ext_rst_n),
        .sw_rst_req   (sw_rst_req),
        .rst_out_n    (rst_out_n),
        .all_released (all_released),
        .last_cause   (last_cause),
        .rst_count    (rst_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        int n = 0;
        while (all_released !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("wait_run", 32'(all_released), 32'd1);
    endtask

    task automatic wait_out(input logic [3:0] pat);
        int n = 0;
        while (rst_out_n !== pat && n < 200) begin
            step();
            n++;
        end
        check("wait_out", 32'(rst_out_n), 32'(pat));
    endtask

    // Checks that the release sequence after an ASSERT entry edge reaches bit 0 at exactly +24.
    task automatic check_stretch(input string tag);
        repeat (23) step();
        check({tag, "_pre"}, 32'(rst_out_n), 32'h0);
        step();
        check({tag, "_bit0"}, 32'(rst_out_n), 32'h1);
    endtask

    initial begin
        reset      = 1'b1;
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
        repeat (5) step();
        check("rst_out",   32'(rst_out_n),    32'h0);
        check("rst_allr",  32'(all_released), 32'h0);
        check("rst_cause", 32'(last_cause),   32'h0);
        check("rst_count", 32'(rst_count),    32'h0);
        reset = 1'b0;

        // Power-on release timing, edges counted from the first with reset low.
        repeat (26) step();
        check("po_e26", 32'(rst_out_n), 32'h0);
        step();
        check("po_e27", 32'(rst_out_n), 32'h1);
        repeat (7) step();
        check("po_e34", 32'(rst_out_n), 32'h1);
        step();
        check("po_e35", 32'(rst_out_n), 32'h3);
        repeat (8) step();
        check("po_e43", 32'(rst_out_n), 32'h7);
        repeat (7) step();
        check("po_e50_allr", 32'(all_released), 32'h0);
        step();
        check("po_e51", 32'(rst_out_n), 32'hF);
        check("po_e51_allr", 32'(all_released), 32'h1);
        check("po_cause", 32'(last_cause), 32'h0);
        check("po_count", 32'(rst_count), 32'h0);

        // Two-cycle pin glitch is ignored.
        ext_rst_n = 1'b0;
        repeat (2) step();
        ext_rst_n = 1'b1;
        repeat (10) step();
        check("gl2_out",   32'(rst_out_n),    32'hF);
        check("gl2_allr",  32'(all_released), 32'h1);
        check("gl2_count", 32'(rst_count),    32'h0);

        // Three-cycle pin low is accepted.
        ext_rst_n = 1'b0;
        repeat (3) step();
        ext_rst_n = 1'b1;
        repeat (2) step();
        check("gl3_hold", 32'(rst_out_n), 32'hF);
        step();
        exp_cnt = 1;
        check("gl3_out",   32'(rst_out_n),  32'h0);
        check("gl3_cause", 32'(last_cause), 32'h1);
        check("gl3_count", 32'(rst_count),  32'(exp_cnt));
        check_stretch("gl3");
        wait_run();

        // Software reset from RUN.
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        exp_cnt++;
        check("sw_out",   32'(rst_out_n),    32'h0);
        check("sw_allr",  32'(all_released), 32'h0);
        check("sw_cause", 32'(last_cause),   32'h2);
        check("sw_count", 32'(rst_count),    32'(exp_cnt));
        check_stretch("sw");

        // Abort mid-release at 0011.
        wait_out(4'h3);
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        exp_cnt++;
        check("ab_out",   32'(rst_out_n), 32'h0);
        check("ab_count", 32'(rst_count), 32'(exp_cnt));
        check_stretch("ab");
        wait_run();

        // Pin and software in the same cycle.
        ext_rst_n = 1'b0;
        repeat (3) step();
        ext_rst_n = 1'b1;
        repeat (2) step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        exp_cnt++;
        check("both_out",   32'(rst_out_n),  32'h0);
        check("both_cause", 32'(last_cause), 32'h3);
        check("both_count", 32'(rst_count),  32'(exp_cnt));
        repeat (5) step();
        check("both_count_hold", 32'(rst_count), 32'(exp_cnt));

        // 300 software events, each issued from RELEASE.
        repeat (11) step();
        for (int i = 0; i < 300; i++) begin
            sw_rst_req = 1'b1;
            step();
            sw_rst_req = 1'b0;
            repeat (16) step();
        end
        check("sat_count", 32'(rst_count),  32'd255);
        check("sat_cause", 32'(last_cause), 32'h2);
        repeat (8) step();
        check("sat_rel", 32'(rst_out_n), 32'h1);

        // Reset mid-release returns everything to reset values on that edge.
        reset = 1'b1;
        step();
        check("mr_out",   32'(rst_out_n),    32'h0);
        check("mr_allr",  32'(all_released), 32'h0);
        check("mr_cause", 32'(last_cause),   32'h0);
        check("mr_count", 32'(rst_count),    32'h0);
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
